// File: rtl/ping_pong_display.sv
// Four-digit multiplexed seven-segment driver for the ping-pong counter: decimal value on
// digits 1:0, direction glyph on digits 3:2, inputs shadowed once per scan frame.
module ping_pong_display #(
  parameter int unsigned SCAN_DIV_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       direction,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [6:0] SegBlank  = 7'b1111111;
  localparam logic [6:0] GlyphUp   = 7'b0011100;
  localparam logic [6:0] GlyphDown = 7'b0100011;

  logic [SCAN_DIV_BITS-1:0] pre_q, pre_d;
  logic [1:0]               sel_q, sel_d;
  logic [3:0]               sh_val_q, sh_val_d;
  logic                     sh_dir_q, sh_dir_d;
  logic [3:0]               an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_q;

  logic       slot_end;
  logic       tens_on;
  logic [3:0] ones;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  assign slot_end = &pre_q;
  assign tens_on  = (sh_val_q >= 4'd10);
  assign ones     = tens_on ? (sh_val_q - 4'd10) : sh_val_q;

  always_comb begin
    pre_d    = pre_q + 1'b1;
    sel_d    = sel_q;
    sh_val_d = sh_val_q;
    sh_dir_d = sh_dir_q;
    if (slot_end) begin
      sel_d = sel_q + 2'd1;
      // Only sampling point: last clock of the frame, so a frame never mixes inputs.
      if (sel_q == 2'd3) begin
        sh_val_d = value;
        sh_dir_d = direction;
      end
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = SegBlank;
    // Last clock of each slot stays dark to avoid ghosting during the digit switch.
    if (!slot_end) begin
      an_d[sel_q] = 1'b0;
      case (sel_q)
        2'd0:    seg_d = enc7(ones);
        2'd1:    seg_d = tens_on ? enc7(4'd1) : SegBlank;
        default: seg_d = sh_dir_q ? GlyphUp : GlyphDown;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      sel_q    <= 2'd0;
      sh_val_q <= 4'd0;
      sh_dir_q <= 1'b1;
      an_q     <= 4'b1111;
      seg_q    <= SegBlank;
      dp_q     <= 1'b1;
    end else begin
      pre_q    <= pre_d;
      sel_q    <= sel_d;
      sh_val_q <= sh_val_d;
      sh_dir_q <= sh_dir_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_ping_pong_display.sv
// Scoreboard bench for ping_pong_display with SCAN_DIV_BITS=2 (slot 4 clocks, frame 16).
module tb_ping_pong_display;

  localparam int unsigned Sdb = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] value = 4'd0;
  logic       direction = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  ping_pong_display #(.SCAN_DIV_BITS(Sdb)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .direction (direction),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         n = 0;
  int         sh_val = 0;
  bit         sh_dir = 1'b1;
  logic [6:0] enc [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h at t=%0t", name, got, want, $time);
    end
  endtask

  // Reference: edge number n since reset release fixes slot position and digit directly.
  task automatic model_edge();
    exp_t       e;
    int         pos;
    int         dig;
    logic [1:0] dsel;
    pos   = n % 4;
    dig   = (n / 4) % 4;
    dsel  = 2'(dig);
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    if (pos != 3) begin
      e.an[dsel] = 1'b0;
      if (dig == 0)      e.seg = enc[sh_val % 10];
      else if (dig == 1) e.seg = (sh_val >= 10) ? enc[1] : 7'b1111111;
      else               e.seg = sh_dir ? 7'b0011100 : 7'b0100011;
    end
    exp_q.push_back(e);
    if (n % 16 == 15) begin
      sh_val = int'(value);
      sh_dir = direction;
    end
    n++;
  endtask

  task automatic step(input logic [3:0] v, input logic d);
    @(negedge clk);
    value     = v;
    direction = d;
    if (!rst) model_edge();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst       = 1'b0;
    n         = 0;
    sh_val    = 0;
    sh_dir    = 1'b1;
    value     = 4'($urandom_range(0, 15));
    direction = 1'($urandom_range(0, 1));
    model_edge();
  endtask

  // Assert reset between edges and confirm blanking without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_an"}, 32'(an), 32'hf);
    check({tag, "_seg"}, 32'(seg), 32'h7f);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    check("dp", 32'(dp), 32'h1);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("an", 32'(an), 32'(mon_e.an));
      check("seg", 32'(seg), 32'(mon_e.seg));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'hf);
    check("rst_seg", 32'(seg), 32'h7f);
    check("rst_dp", 32'(dp), 32'h1);
    release_reset();
    for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    async_reset("async_rst");
    release_reset();

    // Two-digit up: 13 for three frames.
    for (int i = 0; i < 48; i++) step(4'd13, 1'b1);
    // Single digit down.
    for (int i = 0; i < 32; i++) step(4'd7, 1'b0);
    // No tearing: change 13 -> 4 while tens digit is on screen.
    while (n % 16 != 5) step(4'd13, 1'b1);
    for (int i = 0; i < 40; i++) step(4'd4, 1'b1);
    // Inputs churn every clock; only capture edges matter.
    for (int i = 0; i < 64; i++) step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Reset during slot 2 with value 15.
    while (n % 16 != 10) step(4'd15, 1'b1);
    async_reset("mid_rst");
    release_reset();
    for (int i = 0; i < 24; i++) step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
